// File: rtl/control_unit_if.sv
// Bus bundle between the control unit and its instruction memory,
// ALU and register write-back observers.
interface control_unit_if;
    logic [7:0] imem_addr;
    logic [7:0] imem_data;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_op;
    logic [7:0] alu_result;
    logic       wb_valid;
    logic [1:0] wb_addr;
    logic [7:0] wb_data;
    logic       halted;

    modport master (
        output imem_addr,
        input  imem_data,
        output alu_a,
        output alu_b,
        output alu_op,
        input  alu_result,
        output wb_valid,
        output wb_addr,
        output wb_data,
        output halted
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        input  alu_a,
        input  alu_b,
        input  alu_op,
        output alu_result,
        input  wb_valid,
        input  wb_addr,
        input  wb_data,
        input  halted
    );
endinterface

// File: rtl/control_unit.sv
// Fetch/decode/execute sequencer for the 8-bit core: drives the ALU
// from a small register file and handles LDI, JMP and HALT.
module control_unit #(
    parameter int         NREG   = 4,
    parameter logic [7:0] RST_PC = 8'h00
) (
    input logic clk,
    input logic rst,
    control_unit_if.master bus
);
    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_WRITEBACK,
        S_IMM,
        S_HALT
    } state_e;

    localparam logic [2:0] OP_LDI   = 3'b101;
    localparam logic [2:0] OP_JMP   = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;
    localparam logic [2:0] ALU_IDLE = 3'b111;

    state_e     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] ir_q, ir_d;
    logic [7:0] res_q, res_d;
    logic [7:0] regs_q [NREG];
    logic [7:0] regs_d [NREG];
    logic [7:0] alu_a_q, alu_a_d;
    logic [7:0] alu_b_q, alu_b_d;
    logic [2:0] alu_op_q, alu_op_d;
    logic       wb_valid_q, wb_valid_d;
    logic [1:0] wb_addr_q, wb_addr_d;
    logic [7:0] wb_data_q, wb_data_d;
    logic       halted_q, halted_d;

    logic [2:0] op;
    logic [1:0] rd;
    logic [1:0] rs;
    logic       unused_ir;

    assign op        = ir_q[7:5];
    assign rd        = ir_q[4:3];
    assign rs        = ir_q[2:1];
    assign unused_ir = ir_q[0];

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        res_d      = res_q;
        regs_d     = regs_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = ALU_IDLE;
        wb_valid_d = 1'b0;
        wb_addr_d  = wb_addr_q;
        wb_data_d  = wb_data_q;
        halted_d   = halted_q;
        unique case (state_q)
            S_FETCH: begin
                ir_d    = bus.imem_data;
                pc_d    = pc_q + 8'd1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                unique case (1'b1)
                    (op <= 3'd4): begin
                        alu_a_d  = regs_q[rd];
                        alu_b_d  = regs_q[rs];
                        alu_op_d = op;
                        state_d  = S_EXECUTE;
                    end
                    (op == OP_LDI || op == OP_JMP): begin
                        state_d = S_IMM;
                    end
                    (op == OP_HALT): begin
                        halted_d = 1'b1;
                        state_d  = S_HALT;
                    end
                endcase
            end
            S_EXECUTE: begin
                res_d   = bus.alu_result;
                state_d = S_WRITEBACK;
            end
            S_WRITEBACK: begin
                regs_d[rd] = res_q;
                wb_valid_d = 1'b1;
                wb_addr_d  = rd;
                wb_data_d  = res_q;
                state_d    = S_FETCH;
            end
            S_IMM: begin
                // the immediate byte sits at pc, which may have wrapped to 0
                if (op == OP_LDI) begin
                    regs_d[rd] = bus.imem_data;
                    wb_valid_d = 1'b1;
                    wb_addr_d  = rd;
                    wb_data_d  = bus.imem_data;
                    pc_d       = pc_q + 8'd1;
                end else begin
                    pc_d = bus.imem_data;
                end
                state_d = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_FETCH;
            pc_q       <= RST_PC;
            ir_q       <= '0;
            res_q      <= '0;
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= ALU_IDLE;
            wb_valid_q <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            res_q      <= res_d;
            regs_q     <= regs_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            wb_valid_q <= wb_valid_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
            halted_q   <= halted_d;
        end
    end

    assign bus.imem_addr = pc_q;
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_op    = alu_op_q;
    assign bus.wb_valid  = wb_valid_q;
    assign bus.wb_addr   = wb_addr_q;
    assign bus.wb_data   = wb_data_q;
    assign bus.halted    = halted_q;
endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: instruction-level reference model predicts
// per-cycle write-backs, ALU issue, fetch addresses and halt.
module tb_control_unit;
    localparam int MAXC = 128;

    logic clk;
    logic rst;
    logic [7:0] mem [256];

    control_unit_if bus ();

    control_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.imem_data = mem[bus.imem_addr];

    // stand-in ALU seen by the DUT
    always_comb begin
        case (bus.alu_op)
            3'd0:    bus.alu_result = bus.alu_a + bus.alu_b;
            3'd1:    bus.alu_result = bus.alu_a - bus.alu_b;
            3'd2:    bus.alu_result = bus.alu_a & bus.alu_b;
            3'd3:    bus.alu_result = bus.alu_a | bus.alu_b;
            3'd4:    bus.alu_result = bus.alu_a ^ bus.alu_b;
            default: bus.alu_result = 8'h00;
        endcase
    end

    int checks = 0;
    int errors = 0;

    logic       e_wbv  [MAXC];
    logic [1:0] e_wba  [MAXC];
    logic [7:0] e_wbd  [MAXC];
    logic       e_halt [MAXC];
    logic [2:0] e_op   [MAXC];
    logic [7:0] e_a    [MAXC];
    logic [7:0] e_b    [MAXC];
    logic       e_pcv  [MAXC];
    logic [7:0] e_pc   [MAXC];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h t=%0t",
                   tag, obs, exp, $time);
        end
    endtask

    task automatic fill(input logic [7:0] v);
        for (int i = 0; i < 256; i++) mem[i] = v;
    endtask

    // Executes whole instructions; each takes a fixed number of cycles.
    task automatic predict(input int n);
        logic [7:0] rm [4];
        logic [7:0] pc, nx, ins, a, b, r;
        logic [2:0] op;
        logic [1:0] rd, rs;
        int t;
        bit done;
        for (int i = 0; i < MAXC; i++) begin
            e_wbv[i] = 0; e_wba[i] = 0; e_wbd[i] = 0;
            e_halt[i] = 0; e_op[i] = 3'd7; e_a[i] = 0;
            e_b[i] = 0; e_pcv[i] = 0; e_pc[i] = 0;
        end
        for (int i = 0; i < 4; i++) rm[i] = 8'h00;
        pc = 8'h00;
        t = 0;
        done = 0;
        while (t <= n && !done) begin
            ins = mem[pc];
            e_pcv[t] = 1; e_pc[t] = pc;
            op = ins[7:5]; rd = ins[4:3]; rs = ins[2:1];
            nx = pc + 8'd1;
            if (op <= 3'd4) begin
                a = rm[rd]; b = rm[rs];
                case (op)
                    3'd0:    r = a + b;
                    3'd1:    r = a - b;
                    3'd2:    r = a & b;
                    3'd3:    r = a | b;
                    default: r = a ^ b;
                endcase
                e_op[t+2] = op; e_a[t+2] = a; e_b[t+2] = b;
                rm[rd] = r;
                e_wbv[t+4] = 1; e_wba[t+4] = rd; e_wbd[t+4] = r;
                pc = nx;
                t += 4;
            end else if (op == 3'd5) begin
                rm[rd] = mem[nx];
                e_wbv[t+3] = 1; e_wba[t+3] = rd; e_wbd[t+3] = mem[nx];
                pc = nx + 8'd1;
                t += 3;
            end else if (op == 3'd6) begin
                pc = mem[nx];
                t += 3;
            end else begin
                for (int k = t + 2; k <= n; k++) begin
                    e_halt[k] = 1; e_pcv[k] = 1; e_pc[k] = nx;
                end
                done = 1;
            end
        end
    endtask

    task automatic do_reset;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_imem_addr", 32'(bus.imem_addr), 32'h00);
        chk("rst_alu_a", 32'(bus.alu_a), 32'h00);
        chk("rst_alu_b", 32'(bus.alu_b), 32'h00);
        chk("rst_alu_op", 32'(bus.alu_op), 32'h7);
        chk("rst_wb_valid", 32'(bus.wb_valid), 32'h0);
        chk("rst_wb_addr", 32'(bus.wb_addr), 32'h0);
        chk("rst_wb_data", 32'(bus.wb_data), 32'h00);
        chk("rst_halted", 32'(bus.halted), 32'h0);
    endtask

    // Compares cycles 0..n after reset release; ends sitting in cycle n.
    task automatic run_check(input int n);
        predict(n);
        for (int k = 0; k <= n; k++) begin
            chk("wb_valid", 32'(bus.wb_valid), 32'(e_wbv[k]));
            if (e_wbv[k]) begin
                chk("wb_addr", 32'(bus.wb_addr), 32'(e_wba[k]));
                chk("wb_data", 32'(bus.wb_data), 32'(e_wbd[k]));
            end
            chk("halted", 32'(bus.halted), 32'(e_halt[k]));
            chk("alu_op", 32'(bus.alu_op), 32'(e_op[k]));
            if (e_op[k] != 3'd7) begin
                chk("alu_a", 32'(bus.alu_a), 32'(e_a[k]));
                chk("alu_b", 32'(bus.alu_b), 32'(e_b[k]));
            end
            if (e_pcv[k]) begin
                chk("imem_addr", 32'(bus.imem_addr), 32'(e_pc[k]));
            end
            if (k < n) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        fill(8'hE0);

        // LDI R1,05; LDI R2,03; ADD R1,R2; HALT
        mem[0] = 8'hA8; mem[1] = 8'h05;
        mem[2] = 8'hB0; mem[3] = 8'h03;
        mem[4] = 8'h0C; mem[5] = 8'hE0;
        do_reset();
        run_check(16);

        // LDI R0,03; LDI R3,05; SUB R0,R3 -> FE
        fill(8'hE0);
        mem[0] = 8'hA0; mem[1] = 8'h03;
        mem[2] = 8'hB8; mem[3] = 8'h05;
        mem[4] = 8'h26;
        do_reset();
        run_check(14);

        // JMP 10 over a filler of ADDs, HALT at 10
        fill(8'h00);
        mem[0] = 8'hC0; mem[1] = 8'h10;
        mem[8'h10] = 8'hE0;
        do_reset();
        run_check(10);

        // LDI R1 at FF takes its immediate from 00 after wrap
        fill(8'hE0);
        mem[0] = 8'hAA; mem[1] = 8'hE0;
        mem[2] = 8'hC0; mem[3] = 8'hFF;
        mem[8'hFF] = 8'hA8;
        do_reset();
        run_check(16);

        // XOR R1,R1 clears R1
        fill(8'hE0);
        mem[0] = 8'hA8; mem[1] = 8'h5A;
        mem[2] = 8'h8A;
        do_reset();
        run_check(10);

        // reset lands while ADD is in EXECUTE
        fill(8'hE0);
        mem[0] = 8'hA8; mem[1] = 8'h05;
        mem[2] = 8'hB0; mem[3] = 8'h03;
        mem[4] = 8'h0C;
        do_reset();
        run_check(8);
        do_reset();
        run_check(14);

        // hold in HALT for 20+ cycles, then reset and run again
        fill(8'hE0);
        mem[0] = 8'hB0; mem[1] = 8'h77;
        do_reset();
        run_check(28);
        do_reset();
        run_check(8);

        // random programs
        repeat (8) begin
            for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
            do_reset();
            run_check(80);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
